cc_cond_stage: RTL and testbench
================================

Name: cc_cond_stage

Overview:
Consumer end of the execute stage's flag/valE interface for the Y86-64 core.
- Holds the architectural condition-code register (ZF, SF, OF). Loads it from execute-stage flags on OPq.
- Evaluates Cnd for jXX and cmovXX. Gates cmov destination to RNONE when the condition is false.
- Latches the E-to-M pipeline register with stall/bubble control.
- Sits between execute and the memory stage; feeds Cnd back to fetch/PC-select logic.

Parameters:
- DATA_W, 64, width of valE/valA datapath.
- PERF_W, 32, width of optional performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- e_valid  in  1  execute-stage instruction valid.
- stall  in  1  hold M register and CC this cycle.
- bubble  in  1  inject nop into M register.
- exc_block  in  1  downstream exception pending; suppress CC update.
- icode  in  4  execute-stage icode.
- ifun  in  4  execute-stage ifun.
- valE_in  in  DATA_W  ALU result from execute.
- valA_in  in  DATA_W  valA passthrough.
- zf_in, sf_in, of_in  in  1 each  flags produced by execute ALU this cycle.
- dstE_in  in  4  destination register for valE.
- e_cnd  out  1  combinational Cnd from current CC register and ifun.
- e_dstE  out  4  combinational dstE after cmov gating.
- m_valid, m_icode[4], m_cnd, m_valE[DATA_W], m_valA[DATA_W], m_dstE[4]  out  registered E-to-M fields.
- cc_zf, cc_sf, cc_of  out  1 each  current CC register.

Behaviour:
Reset (async assert, sync release):
- cc_zf=1, cc_sf=0, cc_of=0.
- M register holds nop: m_valid=0, m_icode=1, m_cnd=0, m_valE=0, m_valA=0, m_dstE=4'hF.
- Reset mid-operation discards the in-flight M contents immediately.

Cnd evaluation, combinational, from the CC register (not from the *_in flags):
- ifun 0 YES: 1.
- ifun 1 LE: (SF^OF)|ZF.
- ifun 2 L: SF^OF.
- ifun 3 E: ZF.
- ifun 4 NE: !ZF.
- ifun 5 GE: !(SF^OF).
- ifun 6 G: !(SF^OF)&!ZF.
- ifun 7..15: 0.
- e_cnd is forced to 0 unless e_valid and icode is 2 (cmov) or 7 (jXX).

dstE gating:
- e_dstE = 4'hF when icode==2 and e_cnd==0.
- Otherwise e_dstE = dstE_in.

CC update on clock edge:
- Condition: e_valid & icode==6 & !stall & !exc_block & rst_n.
- Loads {zf_in, sf_in, of_in}.
- An OPq and a jXX in consecutive cycles: the jXX sees the new CC (1-cycle latency from OPq edge to e_cnd).
- ifun of OPq is irrelevant to the update.

M register, priority stall > bubble > load:
- stall: all M outputs hold.
- bubble (no stall): nop reset values loaded.
- else: m_valid=e_valid, m_icode=icode, m_cnd=e_cnd, m_valE=valE_in, m_valA=valA_in, m_dstE=e_dstE.
- e_valid=0 with no stall/bubble loads nop values.
- stall and bubble both high: stall wins; no CC update.

Latency:
- Cnd is 0 cycles (combinational).
- M fields are 1 cycle.

Optional Feature:
Macro COND_PERF_CNT_EN.
- Defined: adds outputs jxx_taken_cnt[PERF_W] and jxx_nottaken_cnt[PERF_W].
  - Reset to 0.
  - Increment on each edge where a valid jXX is accepted into M (e_valid & icode==7 & !stall & !bubble): taken if e_cnd, else not-taken.
  - Saturate at all-ones; no wrap.
- Undefined: ports and counters absent; remaining behaviour identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT 0, INOP 1, ICMOVXX 2, IIRMOVQ 3, IRMMOVQ 4, IMRMOVQ 5, IOPQ 6, IJXX 7.
  - Condition constants: C_YES..C_G = 0..6.
  - RNONE = 4'hF.
- One combinational sub-module cond_eval: inputs ifun, zf, sf, of; output cnd.
- CC register, M register and counters stay in cc_cond_stage.

Test Plan:
- Reset then no stimulus -> cc={Z1,S0,O0}, m_icode=1, m_dstE=F, m_valid=0; jle with ifun=1 gives e_cnd=1.
- OPq icode=6 with zf_in=0, sf_in=1, of_in=0, then jXX ifun=2 next cycle -> e_cnd=1 and m_cnd=1; same jXX with ifun=5 -> 0.
- cmovXX icode=2, ifun=3, dstE_in=3, ZF=0 -> e_dstE=F, m_dstE=F; with ZF=1 -> m_dstE=3, m_valE=valE_in.
- OPq with exc_block=1 and flags 0/1/1 -> CC unchanged; same with stall=1 -> CC and M outputs hold for the stall cycle.
- stall=1 & bubble=1 with valid OPq -> M holds, CC unchanged; bubble alone -> M becomes nop next edge.
- Assert rst_n=0 asynchronously mid-cycle after loading m_valE=64'h1234 -> outputs return to reset values before the next clk edge; with COND_PERF_CNT_EN, 3 taken + 2 not-taken jXX -> counters 3 and 2.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, jXX/cmovXX condition codes,
// and the "no register" destination id.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/cc_cond_stage_cond_eval.sv
// cond_eval: combinational condition evaluator for jXX / cmovXX.
// Ports:
//   ifun  - condition selector (0..6 defined, others evaluate false)
//   zf, sf, of - condition-code flags
//   cnd   - condition result
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       cnd
);

    logic lt;

    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_cond_stage.sv
// cc_cond_stage: execute-stage consumer of flags/valE. Holds the condition
// code register, evaluates Cnd for jXX/cmovXX, gates the cmov destination,
// and registers the E-to-M pipeline fields with stall/bubble control.
// Optional macro COND_PERF_CNT_EN adds saturating jXX taken/not-taken
// counters (jxx_taken_cnt, jxx_nottaken_cnt).
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   e_valid, stall, bubble   - pipeline control (stall > bubble > load)
//   exc_block                - suppresses CC update
//   icode, ifun, valE_in, valA_in, dstE_in, zf_in/sf_in/of_in - execute inputs
//   e_cnd, e_dstE            - combinational Cnd and gated dstE
//   m_*                      - registered E-to-M fields
//   cc_zf, cc_sf, cc_of      - condition-code register
module cc_cond_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic              stall,
    input  logic              bubble,
    input  logic              exc_block,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valE_in,
    input  logic [DATA_W-1:0] valA_in,
    input  logic              zf_in,
    input  logic              sf_in,
    input  logic              of_in,
    input  logic [3:0]        dstE_in,
    output logic              e_cnd,
    output logic [3:0]        e_dstE,
    output logic              m_valid,
    output logic [3:0]        m_icode,
    output logic              m_cnd,
    output logic [DATA_W-1:0] m_valE,
    output logic [DATA_W-1:0] m_valA,
    output logic [3:0]        m_dstE,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of
`ifdef COND_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] jxx_taken_cnt,
    output logic [PERF_W-1:0] jxx_nottaken_cnt
`endif
);

    logic              cnd_raw;
    logic              is_cond_op;

    logic [2:0]        cc_q, cc_d;
    logic              m_valid_q, m_valid_d;
    logic [3:0]        m_icode_q, m_icode_d;
    logic              m_cnd_q, m_cnd_d;
    logic [DATA_W-1:0] m_valE_q, m_valE_d;
    logic [DATA_W-1:0] m_valA_q, m_valA_d;
    logic [3:0]        m_dstE_q, m_dstE_d;

    // Cnd comes from the architectural CC, never the flags being produced
    // this cycle; an OPq's flags become visible one edge later.
    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (cc_q[2]),
        .sf   (cc_q[1]),
        .of   (cc_q[0]),
        .cnd  (cnd_raw)
    );

    assign is_cond_op = e_valid && ((icode == ICMOVXX) || (icode == IJXX));
    assign e_cnd      = is_cond_op & cnd_raw;
    assign e_dstE     = ((icode == ICMOVXX) && !e_cnd) ? RNONE : dstE_in;

    always_comb begin
        cc_d = cc_q;
        if (e_valid && (icode == IOPQ) && !stall && !exc_block) begin
            cc_d = {zf_in, sf_in, of_in};
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_valE_d  = m_valE_q;
        m_valA_d  = m_valA_q;
        m_dstE_d  = m_dstE_q;
        if (stall) begin
            // hold everything
        end else if (bubble || !e_valid) begin
            m_valid_d = 1'b0;
            m_icode_d = INOP;
            m_cnd_d   = 1'b0;
            m_valE_d  = '0;
            m_valA_d  = '0;
            m_dstE_d  = RNONE;
        end else begin
            m_valid_d = 1'b1;
            m_icode_d = icode;
            m_cnd_d   = e_cnd;
            m_valE_d  = valE_in;
            m_valA_d  = valA_in;
            m_dstE_d  = e_dstE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q      <= 3'b100;
            m_valid_q <= 1'b0;
            m_icode_q <= INOP;
            m_cnd_q   <= 1'b0;
            m_valE_q  <= '0;
            m_valA_q  <= '0;
            m_dstE_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_valE_q  <= m_valE_d;
            m_valA_q  <= m_valA_d;
            m_dstE_q  <= m_dstE_d;
        end
    end

    assign cc_zf   = cc_q[2];
    assign cc_sf   = cc_q[1];
    assign cc_of   = cc_q[0];
    assign m_valid = m_valid_q;
    assign m_icode = m_icode_q;
    assign m_cnd   = m_cnd_q;
    assign m_valE  = m_valE_q;
    assign m_valA  = m_valA_q;
    assign m_dstE  = m_dstE_q;

`ifdef COND_PERF_CNT_EN
    logic              jxx_accept;
    logic [PERF_W-1:0] taken_q, taken_d;
    logic [PERF_W-1:0] nottaken_q, nottaken_d;

    assign jxx_accept = e_valid && (icode == IJXX) && !stall && !bubble;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        taken_d    = taken_q;
        nottaken_d = nottaken_q;
        if (jxx_accept) begin
            if (e_cnd) begin
                if (taken_q != '1) taken_d = taken_q + 1'b1;
            end else begin
                if (nottaken_q != '1) nottaken_d = nottaken_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else begin
            taken_q    <= taken_d;
            nottaken_q <= nottaken_d;
        end
    end

    assign jxx_taken_cnt    = taken_q;
    assign jxx_nottaken_cnt = nottaken_q;
`endif

endmodule

// File: tb/tb_cc_cond_stage.sv
// Self-checking bench for cc_cond_stage. Directed vectors carry hand-computed
// expectations; post-edge expectations go into a queue that a negedge
// monitor drains and compares.
module tb_cc_cond_stage;

    localparam int DATA_W = 64;
    localparam int PERF_W = 32;

    typedef struct packed {
        logic              valid;
        logic [3:0]        icode;
        logic              cnd;
        logic [DATA_W-1:0] valE;
        logic [DATA_W-1:0] valA;
        logic [3:0]        dstE;
        logic [2:0]        cc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              e_valid = 1'b0, stall = 1'b0, bubble = 1'b0, exc_block = 1'b0;
    logic [3:0]        icode = 4'h1, ifun = 4'h0, dstE_in = 4'hF;
    logic [DATA_W-1:0] valE_in = '0, valA_in = '0;
    logic              zf_in = 1'b0, sf_in = 1'b0, of_in = 1'b0;
    logic              e_cnd, m_valid, m_cnd, cc_zf, cc_sf, cc_of;
    logic [3:0]        e_dstE, m_icode, m_dstE;
    logic [DATA_W-1:0] m_valE, m_valA;
`ifdef COND_PERF_CNT_EN
    logic [PERF_W-1:0] jxx_taken_cnt, jxx_nottaken_cnt;
`endif

    int tests = 0;
    int fails = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cc_cond_stage #(.DATA_W(DATA_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .stall(stall),
        .bubble(bubble), .exc_block(exc_block), .icode(icode), .ifun(ifun),
        .valE_in(valE_in), .valA_in(valA_in), .zf_in(zf_in), .sf_in(sf_in),
        .of_in(of_in), .dstE_in(dstE_in), .e_cnd(e_cnd), .e_dstE(e_dstE),
        .m_valid(m_valid), .m_icode(m_icode), .m_cnd(m_cnd), .m_valE(m_valE),
        .m_valA(m_valA), .m_dstE(m_dstE), .cc_zf(cc_zf), .cc_sf(cc_sf),
        .cc_of(cc_of)
`ifdef COND_PERF_CNT_EN
        , .jxx_taken_cnt(jxx_taken_cnt), .jxx_nottaken_cnt(jxx_nottaken_cnt)
`endif
    );

    function automatic exp_t mk(input logic v, input logic [3:0] ic, input logic c,
                                input logic [DATA_W-1:0] ve, input logic [DATA_W-1:0] va,
                                input logic [3:0] d, input logic [2:0] cc);
        exp_t e;
        e.valid = v; e.icode = ic; e.cnd = c; e.valE = ve; e.valA = va; e.dstE = d; e.cc = cc;
        return e;
    endfunction

    task automatic check_state(input string name, input exp_t e);
        exp_t a;
        a = '{valid: m_valid, icode: m_icode, cnd: m_cnd, valE: m_valE, valA: m_valA,
              dstE: m_dstE, cc: {cc_zf, cc_sf, cc_of}};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got v=%0b ic=%0h cnd=%0b valE=%0h valA=%0h dstE=%0h cc=%03b, expected v=%0b ic=%0h cnd=%0b valE=%0h valA=%0h dstE=%0h cc=%03b",
                     name, a.valid, a.icode, a.cnd, a.valE, a.valA, a.dstE, a.cc,
                     e.valid, e.icode, e.cnd, e.valE, e.valA, e.dstE, e.cc);
        end
    endtask

    // Monitor: M register and CC are presented every cycle; compare against
    // the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_state("m_stage", e);
        end
    end

    // Drive one cycle: inputs applied just after a rising edge, combinational
    // outputs checked immediately, post-edge expectation queued.
    task automatic step(input logic v, input logic st, input logic bb, input logic ex,
                        input logic [3:0] ic, input logic [3:0] fn,
                        input logic [DATA_W-1:0] ve, input logic [DATA_W-1:0] va,
                        input logic [2:0] flags, input logic [3:0] dst,
                        input logic x_cnd, input logic [3:0] x_dstE, input exp_t x_after);
        e_valid = v; stall = st; bubble = bb; exc_block = ex; icode = ic; ifun = fn;
        valE_in = ve; valA_in = va; {zf_in, sf_in, of_in} = flags; dstE_in = dst;
        #1;
        tests++;
        if (e_cnd !== x_cnd || e_dstE !== x_dstE) begin
            fails++;
            $display("FAIL comb ic=%0h fn=%0h: got e_cnd=%0b e_dstE=%0h, expected e_cnd=%0b e_dstE=%0h",
                     ic, fn, e_cnd, e_dstE, x_cnd, x_dstE);
        end
        @(posedge clk);
        #1;
        sb_q.push_back(x_after);
    endtask

    exp_t nop_r, held;

    initial begin
        nop_r = mk(1'b0, 4'h1, 1'b0, '0, '0, 4'hF, 3'b100);
        #12;
        check_state("reset_async", nop_r);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset_idle", nop_r);

        // jle after reset: ZF=1 -> taken
        step(1,0,0,0, 4'h7, 4'h1, 64'h10, 64'h20, 3'b000, 4'hF, 1'b1, 4'hF,
             mk(1, 4'h7, 1, 64'h10, 64'h20, 4'hF, 3'b100));
        // OPq loads Z0 S1 O0
        step(1,0,0,0, 4'h6, 4'h0, 64'h55, 64'h66, 3'b010, 4'h2, 1'b0, 4'h2,
             mk(1, 4'h6, 0, 64'h55, 64'h66, 4'h2, 3'b010));
        // jl sees new CC next cycle
        step(1,0,0,0, 4'h7, 4'h2, 64'h0, 64'h0, 3'b000, 4'hF, 1'b1, 4'hF,
             mk(1, 4'h7, 1, 64'h0, 64'h0, 4'hF, 3'b010));
        // jge not taken
        step(1,0,0,0, 4'h7, 4'h5, 64'h0, 64'h0, 3'b000, 4'hF, 1'b0, 4'hF,
             mk(1, 4'h7, 0, 64'h0, 64'h0, 4'hF, 3'b010));
        // cmove with ZF=0 -> dstE gated
        step(1,0,0,0, 4'h2, 4'h3, 64'h77, 64'h0, 3'b000, 4'h3, 1'b0, 4'hF,
             mk(1, 4'h2, 0, 64'h77, 64'h0, 4'hF, 3'b010));
        // OPq sets ZF
        step(1,0,0,0, 4'h6, 4'h1, 64'h0, 64'h0, 3'b100, 4'h4, 1'b0, 4'h4,
             mk(1, 4'h6, 0, 64'h0, 64'h0, 4'h4, 3'b100));
        // cmove with ZF=1 -> moves
        step(1,0,0,0, 4'h2, 4'h3, 64'hABC, 64'h1, 3'b000, 4'h3, 1'b1, 4'h3,
             mk(1, 4'h2, 1, 64'hABC, 64'h1, 4'h3, 3'b100));
        // OPq blocked by exception: M loads, CC holds
        step(1,0,0,1, 4'h6, 4'h0, 64'h99, 64'h2, 3'b011, 4'h5, 1'b0, 4'h5,
             mk(1, 4'h6, 0, 64'h99, 64'h2, 4'h5, 3'b100));
        held = mk(1, 4'h6, 0, 64'h99, 64'h2, 4'h5, 3'b100);
        // stall: M and CC hold
        step(1,1,0,0, 4'h6, 4'h0, 64'hEE, 64'hEE, 3'b011, 4'h5, 1'b0, 4'h5, held);
        // stall + bubble: stall wins
        step(1,1,1,0, 4'h6, 4'h0, 64'hEE, 64'hEE, 3'b011, 4'h7, 1'b0, 4'h7, held);
        // bubble alone: nop
        step(1,0,1,0, 4'h7, 4'h0, 64'hEE, 64'hEE, 3'b000, 4'hF, 1'b1, 4'hF, nop_r);
        // invalid jXX: e_cnd forced 0, M gets nop
        step(0,0,0,0, 4'h7, 4'h0, 64'hEE, 64'hEE, 3'b000, 4'h6, 1'b0, 4'h6, nop_r);
        // cmov always (YES) still allowed through
        step(1,0,0,0, 4'h2, 4'h0, 64'h3, 64'h4, 3'b000, 4'h8, 1'b1, 4'h8,
             mk(1, 4'h2, 1, 64'h3, 64'h4, 4'h8, 3'b100));
        // OPq Z0 S1 O1 -> non-reset CC
        step(1,0,0,0, 4'h6, 4'h0, 64'h5, 64'h0, 3'b011, 4'h0, 1'b0, 4'h0,
             mk(1, 4'h6, 0, 64'h5, 64'h0, 4'h0, 3'b011));
        // jg: lt=0, ZF=0 -> taken; jle -> not taken checked next
        step(1,0,0,0, 4'h7, 4'h6, 64'h0, 64'h0, 3'b000, 4'hF, 1'b1, 4'hF,
             mk(1, 4'h7, 1, 64'h0, 64'h0, 4'hF, 3'b011));
        step(1,0,0,0, 4'h7, 4'h1, 64'h0, 64'h0, 3'b000, 4'hF, 1'b0, 4'hF,
             mk(1, 4'h7, 0, 64'h0, 64'h0, 4'hF, 3'b011));
        // load m_valE=0x1234 then reset mid-cycle
        step(1,0,0,0, 4'h3, 4'h0, 64'h1234, 64'h0, 3'b000, 4'h1, 1'b0, 4'h1,
             mk(1, 4'h3, 0, 64'h1234, 64'h0, 4'h1, 3'b011));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("reset_midcycle", nop_r);
        e_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // jXX counter exercise: 3 taken (YES), 2 not-taken (ifun 7)
        for (int i = 0; i < 3; i++)
            step(1,0,0,0, 4'h7, 4'h0, 64'h0, 64'h0, 3'b000, 4'hF, 1'b1, 4'hF,
                 mk(1, 4'h7, 1, 64'h0, 64'h0, 4'hF, 3'b100));
        for (int i = 0; i < 2; i++)
            step(1,0,0,0, 4'h7, 4'h7, 64'h0, 64'h0, 3'b000, 4'hF, 1'b0, 4'hF,
                 mk(1, 4'h7, 0, 64'h0, 64'h0, 4'hF, 3'b100));
        // a bubbled jXX must not count
        step(1,0,1,0, 4'h7, 4'h0, 64'h0, 64'h0, 3'b000, 4'hF, 1'b1, 4'hF, nop_r);
        e_valid = 1'b0;
        @(negedge clk);
        #1;
`ifdef COND_PERF_CNT_EN
        tests++;
        if (jxx_taken_cnt !== 32'd3 || jxx_nottaken_cnt !== 32'd2) begin
            fails++;
            $display("FAIL perf_cnt: got taken=%0d nottaken=%0d, expected 3 and 2",
                     jxx_taken_cnt, jxx_nottaken_cnt);
        end
`endif
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
